// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter and fetch sequencer sitting directly in front of the
//   instruction decoder. A start pulse loads start_addr and enters RUN. In RUN
//   one instruction retires per clock. The decoder's halt, jump and branch
//   results select the next PC. A saturating counter tracks retired
//   instructions since the last accepted start.
//
// Ports
//   CLK          system clock, rising edge
//   reset        synchronous active-high reset, dominates every other input
//   start        single-cycle pulse, accepted in IDLE or HALTED only
//   start_addr   first instruction address, sampled with an accepted start
//   halt_in      decoder Halt for the instruction at pc
//   jump_en      unconditional relative jump
//   branch_en    conditional relative branch
//   branch_cond  branch condition from the datapath flag (1 = take)
//   offset       signed relative displacement, OFF_W bits
//   pc           current instruction-ROM address (registered)
//   running      high while in RUN (registered)
//   done         high while in HALTED (registered)
//   inst_count   instructions retired since the last accepted start

module pc_fetch_unit #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 9,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             halt_in,
  input  logic             jump_en,
  input  logic             branch_en,
  input  logic             branch_cond,
  input  logic [OFF_W-1:0] offset,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_reg;
  logic [PC_W-1:0]  pc_reg;
  logic             running_reg;
  logic             done_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Offset brought to PC width: sign-extended when narrower than the PC,
  // truncated to the low PC_W bits when wider.
  logic [PC_W-1:0] off_ext;

  genvar gi;
  generate
    for (gi = 0; gi < PC_W; gi++) begin : g_off_ext
      if (gi < OFF_W) begin : g_copy
        assign off_ext[gi] = offset[gi];
      end else begin : g_sign
        assign off_ext[gi] = offset[OFF_W-1];
      end
    end
  endgenerate

  // Next PC while running and not halting. Jump and taken branch share the
  // same relative target, so jump-over-branch priority needs no extra mux.
  // Addition is modulo 2^PC_W, so wrap in either direction is silent.
  logic [PC_W-1:0] pc_next;

  always_comb begin
    pc_next = pc_reg + PC_W'(1);
    if (jump_en || (branch_en && branch_cond)) begin
      pc_next = pc_reg + off_ext;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= '0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_HALTED: begin
          // Control inputs are ignored here; only start can change state.
          if (start) begin
            state_reg   <= ST_RUN;
            pc_reg      <= start_addr;
            cnt_reg     <= '0;
            running_reg <= 1'b1;
            done_reg    <= 1'b0;
          end
        end

        ST_RUN: begin
          // Every RUN cycle retires the instruction at pc, including a halt.
          if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
          if (halt_in) begin
            state_reg   <= ST_HALTED;
            running_reg <= 1'b0;
            done_reg    <= 1'b1;
          end else begin
            pc_reg <= pc_next;
          end
        end

        default: begin
          state_reg   <= ST_IDLE;
          pc_reg      <= '0;
          running_reg <= 1'b0;
          done_reg    <= 1'b0;
          cnt_reg     <= '0;
        end
      endcase
    end
  end

  assign pc         = pc_reg;
  assign running    = running_reg;
  assign done       = done_reg;
  assign inst_count = cnt_reg;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage directly upstream of the instruction decoder.
- Holds the PC that addresses the instruction ROM and runs a start/run/halt sequencer.
- Applies the decoder's Halt, jump and branch results to choose the next PC.
- Counts retired instructions for the testbench and performance reporting.

Parameters:
PC_W, 10, PC / instruction-ROM address width in bits
OFF_W, 9, width of the decoder's branch/jump offset (two's-complement, relative)
CNT_W, 16, width of the retired-instruction counter

Ports:
CLK  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse: begin execution at start_addr
start_addr  input  PC_W  first instruction address, sampled when start is accepted
halt_in  input  1  decoder Halt for the instruction at pc
jump_en  input  1  current instruction is an unconditional jump
branch_en  input  1  current instruction is a conditional branch (BEO/BEZ)
branch_cond  input  1  branch condition from datapath flag (1 = take)
offset  input  OFF_W  decoder Offset, signed relative displacement
pc  output  PC_W  current instruction address to instruction ROM
running  output  1  high while in RUN
done  output  1  high while in HALTED
inst_count  output  CNT_W  instructions retired since last accepted start

Behaviour:
- States: IDLE, RUN, HALTED. Registered state; pc, running, done and inst_count are registers or decoded directly from state.
- Reset (synchronous, active-high) on any cycle, including mid-RUN:
  - next state IDLE; pc=0, running=0, done=0, inst_count=0.
  - reset dominates start and every other input.
- IDLE:
  - start=1: pc<=start_addr, inst_count<=0, go to RUN (running=1 the next cycle).
  - start=0: hold all state.
- RUN, one instruction per cycle; instruction at pc is treated as retired at the clock edge.
  - inst_count<=inst_count+1 every RUN cycle; saturates at all-ones, no wrap.
  - Next-PC priority:
    1. halt_in=1: pc holds, go to HALTED (done=1, running=0 the next cycle). The halt instruction is counted.
    2. jump_en=1: pc<=pc+sext(offset).
    3. branch_en=1 and branch_cond=1: pc<=pc+sext(offset).
    4. otherwise (including branch not taken): pc<=pc+1.
  - Arithmetic is modulo 2^PC_W. offset is sign-extended from OFF_W to PC_W; if OFF_W>PC_W, offset is truncated to PC_W.
  - Wrap-around in either direction is legal and silent: 1023+1 -> 0; 0 + (-1) -> 1023.
  - start is ignored in RUN; start_addr is not sampled.
  - jump_en and branch_en both high: jump wins; the result is identical.
- HALTED:
  - pc, inst_count and done=1 hold.
  - start=1: pc<=start_addr, inst_count<=0, go to RUN; done deasserts the next cycle.
- Outside RUN, halt_in, jump_en, branch_en, branch_cond and offset are don't-care and must not change state.
- Latency:
  - start accepted to first pc = start_addr visible: 1 cycle.
  - Control inputs to next pc: 1 cycle.
  - No combinational path from any input to any output.
- running and done are never high simultaneously. Both are low only in IDLE.

Test Plan:
- Reset/start: hold reset 2 cycles, then start=1 with start_addr=0x010 -> pc=0, done=0 during reset; pc=0x010, running=1 one cycle after start; sequential run gives 0x011, 0x012, 0x013.
- Branch/jump: pc=0x020 with jump_en=1, offset=9'h1F6 (-10) -> pc=0x016. branch_en=1, branch_cond=0 -> pc+1. branch_en=1, branch_cond=1, offset=+5 -> pc+5.
- Wrap: pc=0x3FF, no control -> pc=0x000. pc=0x002, jump offset=-3 -> pc=0x3FF.
- Halt and restart: start at 0x000, 4 sequential instructions, then halt_in=1 at pc=0x004 -> done=1, running=0, pc=0x004, inst_count=5 held over 10 cycles. Then start with start_addr=0x100 -> RUN, pc=0x100, inst_count=0, done=0.
- Priority/ignore:
  - halt_in=1 with jump_en=1 -> halt wins, pc unchanged.
  - start pulse mid-RUN -> no effect on pc.
  - jump_en toggled in IDLE -> pc stays 0.
- Reset mid-run and saturation: reset asserted while RUN at pc=0x055 -> next cycle IDLE, pc=0, inst_count=0. Preload scenario with CNT_W=4 running 20 cycles -> inst_count sticks at 4'hF.
